imm_decode_stage: RTL

Registered immediate-decode stage for the decode pipeline, parametrised in datapath width and in optional RV32C immediate support, and adding a CSR zimm format. It accepts one fetched instruction per valid/ready handshake and presents the sign-extended immediate, a format code and the passed-through PC and instruction one cycle later. An optional skid buffer gives full throughput under backpressure, and a flush input discards everything in flight.

---
 rtl/cpu_pkg.sv | 50 +++++
 rtl/imm_extract.sv | 112 +++++++++++
 rtl/imm_decode_stage.sv | 132 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared decode definitions: immediate format codes, RV32 opcodes and RVC
// quadrant/funct3 constants used by the immediate decode stage.
package cpu_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } imm_fmt_t;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    localparam logic [1:0] RVC_Q0 = 2'b00;
    localparam logic [1:0] RVC_Q1 = 2'b01;
    localparam logic [1:0] RVC_Q2 = 2'b10;

    localparam logic [2:0] C0_ADDI4SPN = 3'b000;
    localparam logic [2:0] C0_LW       = 3'b010;
    localparam logic [2:0] C0_SW       = 3'b110;
    localparam logic [2:0] C1_ADDI     = 3'b000;
    localparam logic [2:0] C1_JAL      = 3'b001;
    localparam logic [2:0] C1_LI       = 3'b010;
    localparam logic [2:0] C1_LUI      = 3'b011;
    localparam logic [2:0] C1_J        = 3'b101;
    localparam logic [2:0] C1_BEQZ     = 3'b110;
    localparam logic [2:0] C1_BNEZ     = 3'b111;
    localparam logic [2:0] C2_LWSP     = 3'b010;
    localparam logic [2:0] C2_SWSP     = 3'b110;

    // Per-beat metadata carried alongside the immediate and PC
    typedef struct packed {
        imm_fmt_t    fmt;
        logic        is_rvc;
        logic [31:0] instr;
    } beat_meta_t;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction: maps one instruction word to its
// sign/zero-extended immediate, format code and compressed flag.
module imm_extract
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter bit          RVC_EN = 1'b0
) (
    input  logic [31:0]     i_instr,
    output logic [XLEN-1:0] o_imm_c,
    output logic [2:0]      o_fmt_c,
    output logic            o_is_rvc_c
);

    always_comb begin
        o_imm_c    = '0;
        o_fmt_c    = FMT_NONE;
        o_is_rvc_c = 1'b0;
        if (i_instr[1:0] == 2'b11) begin
            case (i_instr[6:0])
                OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                    o_imm_c = XLEN'($signed(i_instr[31:20]));
                    o_fmt_c = FMT_I;
                end
                OPC_OP_IMM_32: begin
                    if (XLEN == 64) begin
                        o_imm_c = XLEN'($signed(i_instr[31:20]));
                        o_fmt_c = FMT_I;
                    end
                end
                OPC_STORE: begin
                    o_imm_c = XLEN'($signed({i_instr[31:25], i_instr[11:7]}));
                    o_fmt_c = FMT_S;
                end
                OPC_BRANCH: begin
                    o_imm_c = XLEN'($signed({i_instr[31], i_instr[7], i_instr[30:25],
                                             i_instr[11:8], 1'b0}));
                    o_fmt_c = FMT_B;
                end
                OPC_LUI, OPC_AUIPC: begin
                    o_imm_c = XLEN'($signed({i_instr[31:12], 12'b0}));
                    o_fmt_c = FMT_U;
                end
                OPC_JAL: begin
                    o_imm_c = XLEN'($signed({i_instr[31], i_instr[19:12], i_instr[20],
                                             i_instr[30:21], 1'b0}));
                    o_fmt_c = FMT_J;
                end
                OPC_SYSTEM: begin
                    // CSR*I variants: funct3 101/110/111 carry zimm in the rs1 field
                    if (i_instr[14] && (i_instr[13:12] != 2'b00)) begin
                        o_imm_c = XLEN'(i_instr[19:15]);
                        o_fmt_c = FMT_Z;
                    end
                end
                default: ;
            endcase
        end else if (RVC_EN) begin
            o_is_rvc_c = 1'b1;
            case ({i_instr[1:0], i_instr[15:13]})
                {RVC_Q0, C0_ADDI4SPN}: begin
                    o_imm_c = XLEN'({i_instr[10:7], i_instr[12:11], i_instr[5], i_instr[6], 2'b00});
                    o_fmt_c = FMT_I;
                end
                {RVC_Q0, C0_LW}: begin
                    o_imm_c = XLEN'({i_instr[5], i_instr[12:10], i_instr[6], 2'b00});
                    o_fmt_c = FMT_I;
                end
                {RVC_Q0, C0_SW}: begin
                    o_imm_c = XLEN'({i_instr[5], i_instr[12:10], i_instr[6], 2'b00});
                    o_fmt_c = FMT_S;
                end
                {RVC_Q1, C1_ADDI}, {RVC_Q1, C1_LI}: begin
                    o_imm_c = XLEN'($signed({i_instr[12], i_instr[6:2]}));
                    o_fmt_c = FMT_I;
                end
                {RVC_Q1, C1_LUI}: begin
                    // rd == x2 selects C.ADDI16SP in the C.LUI slot
                    if (i_instr[11:7] == 5'd2) begin
                        o_imm_c = XLEN'($signed({i_instr[12], i_instr[4:3], i_instr[5],
                                                 i_instr[2], i_instr[6], 4'b0000}));
                        o_fmt_c = FMT_I;
                    end else begin
                        o_imm_c = XLEN'($signed({i_instr[12], i_instr[6:2], 12'b0}));
                        o_fmt_c = FMT_U;
                    end
                end
                {RVC_Q1, C1_JAL}, {RVC_Q1, C1_J}: begin
                    o_imm_c = XLEN'($signed({i_instr[12], i_instr[8], i_instr[10:9], i_instr[6],
                                             i_instr[7], i_instr[2], i_instr[11], i_instr[5:3],
                                             1'b0}));
                    o_fmt_c = FMT_J;
                end
                {RVC_Q1, C1_BEQZ}, {RVC_Q1, C1_BNEZ}: begin
                    o_imm_c = XLEN'($signed({i_instr[12], i_instr[6:5], i_instr[2],
                                             i_instr[11:10], i_instr[4:3], 1'b0}));
                    o_fmt_c = FMT_B;
                end
                {RVC_Q2, C2_LWSP}: begin
                    o_imm_c = XLEN'({i_instr[3:2], i_instr[12], i_instr[6:4], 2'b00});
                    o_fmt_c = FMT_I;
                end
                {RVC_Q2, C2_SWSP}: begin
                    o_imm_c = XLEN'({i_instr[8:7], i_instr[12:9], 2'b00});
                    o_fmt_c = FMT_S;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode pipeline stage with valid/ready handshake,
// optional 2-entry skid buffer and flush.
module imm_decode_stage
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter bit          RVC_EN = 1'b0,
    parameter bit          SKID   = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_flush,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [31:0]     i_in_instr,
    input  logic [XLEN-1:0] i_in_pc,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [XLEN-1:0] o_out_imm,
    output logic [2:0]      o_out_fmt,
    output logic            o_out_is_rvc,
    output logic [31:0]     o_out_instr,
    output logic [XLEN-1:0] o_out_pc
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_decode_stage: XLEN must be 32 or 64");
    end
    if (RVC_EN && XLEN == 64) begin : g_bad_rvc
        $error("imm_decode_stage: RVC_EN requires XLEN=32");
    end

    logic [XLEN-1:0] w_imm;
    logic [2:0]      w_fmt;
    logic            w_is_rvc;
    beat_meta_t      w_new_meta;
    logic            w_in_fire;
    logic            w_out_load;

    logic            r_out_valid;
    logic [XLEN-1:0] r_out_imm;
    logic [XLEN-1:0] r_out_pc;
    beat_meta_t      r_out_meta;

    imm_extract #(
        .XLEN   (XLEN),
        .RVC_EN (RVC_EN)
    ) u_extract (
        .i_instr    (i_in_instr),
        .o_imm_c    (w_imm),
        .o_fmt_c    (w_fmt),
        .o_is_rvc_c (w_is_rvc)
    );

    assign w_new_meta = '{fmt: imm_fmt_t'(w_fmt), is_rvc: w_is_rvc, instr: i_in_instr};
    assign w_in_fire  = i_in_valid && o_in_ready;
    assign w_out_load = !r_out_valid || i_out_ready;

    if (SKID) begin : g_skid
        logic            r_skid_valid;
        logic [XLEN-1:0] r_skid_imm;
        logic [XLEN-1:0] r_skid_pc;
        beat_meta_t      r_skid_meta;

        assign o_in_ready = !r_skid_valid;

        // Output register refills from skid first, else straight from the input
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_out_valid  <= 1'b0;
                r_out_imm    <= '0;
                r_out_pc     <= '0;
                r_out_meta   <= '0;
                r_skid_valid <= 1'b0;
                r_skid_imm   <= '0;
                r_skid_pc    <= '0;
                r_skid_meta  <= '0;
            end else if (i_flush) begin
                r_out_valid  <= 1'b0;
                r_skid_valid <= 1'b0;
            end else if (w_out_load) begin
                if (r_skid_valid) begin
                    r_out_valid  <= 1'b1;
                    r_out_imm    <= r_skid_imm;
                    r_out_pc     <= r_skid_pc;
                    r_out_meta   <= r_skid_meta;
                    r_skid_valid <= 1'b0;
                end else begin
                    r_out_valid <= w_in_fire;
                    if (w_in_fire) begin
                        r_out_imm  <= w_imm;
                        r_out_pc   <= i_in_pc;
                        r_out_meta <= w_new_meta;
                    end
                end
            end else if (w_in_fire) begin
                r_skid_valid <= 1'b1;
                r_skid_imm   <= w_imm;
                r_skid_pc    <= i_in_pc;
                r_skid_meta  <= w_new_meta;
            end
        end
    end else begin : g_noskid
        assign o_in_ready = w_out_load;

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_out_valid <= 1'b0;
                r_out_imm   <= '0;
                r_out_pc    <= '0;
                r_out_meta  <= '0;
            end else if (i_flush) begin
                r_out_valid <= 1'b0;
            end else if (w_out_load) begin
                r_out_valid <= w_in_fire;
                if (w_in_fire) begin
                    r_out_imm  <= w_imm;
                    r_out_pc   <= i_in_pc;
                    r_out_meta <= w_new_meta;
                end
            end
        end
    end

    assign o_out_valid  = r_out_valid;
    assign o_out_imm    = r_out_imm;
    assign o_out_pc     = r_out_pc;
    assign o_out_fmt    = r_out_meta.fmt;
    assign o_out_is_rvc = r_out_meta.is_rvc;
    assign o_out_instr  = r_out_meta.instr;

endmodule
